// File: rtl/mux2_arbiter_if.sv
// Bundle for the two-requester mux arbiter: both request channels plus the
// single downstream valid/ready channel.
//   slave  : arbiter side (takes requests, drives acks, sel and output beat)
//   master : source/consumer side (drives requests, data and out_ready)
interface mux2_arbiter_if #(
  parameter int W = 8
);
  logic         req_a;
  logic [W-1:0] data_a;
  logic         ack_a;
  logic         req_b;
  logic [W-1:0] data_b;
  logic         ack_b;
  logic         sel;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;

  modport slave (
    input  req_a, data_a, req_b, data_b, out_ready,
    output ack_a, ack_b, sel, out_valid, out_data
  );

  modport master (
    output req_a, data_a, req_b, data_b, out_ready,
    input  ack_a, ack_b, sel, out_valid, out_data
  );
endinterface

// File: rtl/mux2_arbiter.sv
// Shares one 2:1 data mux between requesters A and B. Round-robin with a
// bounded burst allowance: the last winner may keep winning ties until it has
// BURST consecutive wins, then the other side gets the next tie.
//
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - mux2_arbiter_if.slave: req/data/ack per requester, registered
//           sel, out_valid/out_ready/out_data downstream channel
//
// state | meaning
// IDLE  | no beat presented; arbitrate between pending requests
// GNT_A | A's beat on out_data, waiting for out_ready (or A abort)
// GNT_B | B's beat on out_data, waiting for out_ready (or B abort)
module mux2_arbiter #(
  parameter int W     = 8,
  parameter int BURST = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  mux2_arbiter_if.slave bus
);

  localparam int CW = (BURST < 1) ? 1 : $clog2(BURST + 1);
  localparam logic [CW-1:0] BURST_C = CW'(BURST);

  typedef enum logic [1:0] {IDLE, GNT_A, GNT_B} state_t;

  state_t         state_q, state_d;
  logic           sel_q, sel_d;
  logic           last_q, last_d;   // 0 = A, 1 = B
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           win_any;
  logic           win_b;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    win_any = bus.req_a | bus.req_b;
    win_b   = bus.req_b;
    // Tie: the last winner keeps the grant only while under its burst budget.
    if (bus.req_a && bus.req_b) begin
      win_b = (cnt_q < BURST_C) ? last_q : ~last_q;
    end

    case (state_q)
      IDLE: begin
        if (win_any) begin
          state_d = win_b ? GNT_B : GNT_A;
          sel_d   = win_b;
          if (win_b == last_q) begin
            cnt_d = (cnt_q == BURST_C) ? cnt_q : cnt_q + 1'b1;
          end else begin
            cnt_d  = CW'(1);
            last_d = win_b;
          end
        end
      end
      // Handshake or requester abort both return to IDLE; an abort leaves
      // last/cnt as they were set at grant time.
      GNT_A: if (bus.out_ready || !bus.req_a) state_d = IDLE;
      GNT_B: if (bus.out_ready || !bus.req_b) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
      last_q  <= 1'b1;      // "last = B" so the first tie goes to A
      cnt_q   <= BURST_C;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.out_valid = (state_q == GNT_A) | (state_q == GNT_B);
  assign bus.ack_a     = bus.out_valid & bus.out_ready & (state_q == GNT_A);
  assign bus.ack_b     = bus.out_valid & bus.out_ready & (state_q == GNT_B);
  assign bus.sel       = sel_q;
  assign bus.out_data  = sel_q ? bus.data_b : bus.data_a;

endmodule
